// File: rtl/fft_loader_pkg.sv
// fft_loader_pkg: shared types and constants for the FFT input loader.
//   loader_state_t : loader FSM encoding, also visible on status_o[1:0]
//   sample_t       : one input sample at the default width
//   ST_*           : bit positions of the fields packed into status_o
package fft_loader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10,
    ERROR  = 2'b11
  } loader_state_t;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] sample_t;

  // status_o layout: [1:0] state, [2] sticky error, [7:3] frame count
  localparam int ST_STATE_LSB = 0;
  localparam int ST_STATE_W   = 2;
  localparam int ST_ERR_BIT   = 2;
  localparam int ST_CNT_LSB   = 3;
  localparam int ST_CNT_W     = 5;

endpackage

// File: rtl/fft_bitrev.sv
// fft_bitrev: purely combinational index reverser.
//   idx     : LOG2_N-bit natural index
//   rev_idx : the same index with its bit order mirrored
module fft_bitrev #(
  parameter int LOG2_N = 4
) (
  input  logic [LOG2_N-1:0] idx,
  output logic [LOG2_N-1:0] rev_idx
);

  always_comb begin
    rev_idx = '0;
    for (int b = 0; b < LOG2_N; b++) begin
      rev_idx[b] = idx[LOG2_N-1-b];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: input-reorder stage in front of the FFT datapath.
// Collects one frame of N = 2^LOG2_N samples, stores each at its
// bit-reversed index, then replays the frame in natural order.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_i                 arm a frame load (IDLE only)
//   clear_i                 abort / clear sticky error (any state)
//   s_data_i/s_valid_i/s_last_i, s_ready_o   input sample stream
//   m_data_o/m_addr_o/m_valid_o, m_ready_i   reordered output stream
//   status_o                [1:0] state, [2] error, [7:3] frame count
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; ready and valid are decoded from
// registered state only, so no input reaches an output combinationally.
// While m_valid_o is high and m_ready_i is low, m_data_o/m_addr_o hold.
module fft_input_loader
  import fft_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_N     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [LOG2_N-1:0]     m_addr_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [7:0]            status_o
);

  localparam int                N        = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);
  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);

  loader_state_t         state_q, state_d;
  logic [LOG2_N-1:0]     wr_idx_q, rd_idx_q, wr_rev;
  logic                  err_q;
  logic [ST_CNT_W-1:0]   frame_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [N];
  logic                  in_xfer, out_xfer;

  assign in_xfer  = s_valid_i & (state_q == ACTIVE);
  assign out_xfer = m_ready_i & (state_q == DONE);

  fft_bitrev #(.LOG2_N(LOG2_N)) u_bitrev (
    .idx     (wr_idx_q),
    .rev_idx (wr_rev)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; clear_i overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_i) state_d = ACTIVE;
      ACTIVE: begin
        if (in_xfer) begin
          if (s_last_i && (wr_idx_q == LAST_IDX))     state_d = DONE;
          else if (s_last_i || (wr_idx_q == LAST_IDX)) state_d = ERROR;
        end
      end
      DONE:   if (out_xfer && (rd_idx_q == LAST_IDX)) state_d = IDLE;
      ERROR:  state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Output decode from registered state and datapath registers only
  always_comb begin
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_addr_o  = '0;
    case (state_q)
      ACTIVE: s_ready_o = 1'b1;
      DONE: begin
        m_valid_o = 1'b1;
        m_data_o  = mem_q[rd_idx_q];
        m_addr_o  = rd_idx_q;
      end
      default: ;
    endcase
    status_o = {frame_cnt_q, err_q, state_q};
  end

  // Datapath: indices, sticky error, frame counter, sample buffer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      // Abort: buffer and frame count are deliberately kept
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_i) wr_idx_q <= '0;

      if (in_xfer) begin
        mem_q[wr_rev] <= s_data_i;
        wr_idx_q      <= wr_idx_q + IDX_ONE;
      end

      if ((state_q == ACTIVE) && (state_d == ERROR)) err_q <= 1'b1;
      if ((state_q == ACTIVE) && (state_d == DONE))  rd_idx_q <= '0;

      if (out_xfer) begin
        rd_idx_q <= rd_idx_q + IDX_ONE;
        if (rd_idx_q == LAST_IDX) frame_cnt_q <= frame_cnt_q + 5'd1;
      end
    end
  end

endmodule
